// File: rtl/lcd_responder.sv
// Device-side model of a memory-mapped HD44780-style character LCD: acts on
// enable falling edges, keeps a 2x16 character buffer, cursor and busy timing.
module lcd_responder #(
  parameter int CMD_CYCLES   = 8,
  parameter int CLEAR_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_data,
  input  logic [1:0] lcd_ctrl,
  input  logic       lcd_enable,
  output logic [7:0] lcd_rdata,
  output logic       busy,
  output logic       display_on,
  output logic [6:0] cursor,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic [6:0] char_addr,
  output logic       dropped,
  input  logic [4:0] view_addr,
  output logic [7:0] view_char
);

  localparam int CW = $clog2(CLEAR_CYCLES > CMD_CYCLES ? CLEAR_CYCLES : CMD_CYCLES) + 1;
  localparam logic [CW-1:0] LP_CMD_LAST = CW'(CMD_CYCLES - 1);
  localparam logic [CW-1:0] LP_CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] LP_SWEEP_N  = CW'(32);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [1:0] CTRL_CMD_WR  = 2'b00;
  localparam logic [1:0] CTRL_STAT_RD = 2'b01;
  localparam logic [1:0] CTRL_DATA_WR = 2'b10;
  localparam logic [1:0] CTRL_DATA_RD = 2'b11;

  logic [7:0]    r_buf [32];
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_en_q;
  logic          r_inc;
  logic [6:0]    r_cursor;
  logic          r_display_on;
  logic [7:0]    r_rdata;
  logic          r_char_valid;
  logic [7:0]    r_char_data;
  logic [6:0]    r_char_addr;
  logic          r_dropped;

  logic          w_strobe;
  logic          w_idle;
  logic          w_accept;
  logic [4:0]    w_cur_idx;
  logic [6:0]    w_cur_next;
  logic [CW-1:0] w_sweep_off;
  logic          w_sweep_on;

  // Line wrap: line 0 ends at 0x0F and continues at 0x40, line 1 ends at 0x4F.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) n = (a[3:0] == 4'hF) ? (a[6] ? 7'h00 : 7'h40) : a + 7'd1;
    else     n = (a[3:0] == 4'h0) ? (a[6] ? 7'h0F : 7'h4F) : a - 7'd1;
    return n;
  endfunction

  assign w_strobe    = r_en_q & ~lcd_enable;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_strobe & w_idle;
  assign w_cur_idx   = {r_cursor[6], r_cursor[3:0]};
  assign w_cur_next  = step_addr(r_cursor, r_inc);
  // The sweep occupies the first 32 cycles of CLEAR, cell index = elapsed cycles.
  assign w_sweep_off = LP_CLR_LAST - r_cnt;
  assign w_sweep_on  = (r_state == ST_CLEAR) && (w_sweep_off < LP_SWEEP_N);

  // NOTE: the character buffer is a register array with async reset on purpose:
  // a reset must leave every cell at 0x20, so it cannot map onto a reset-less RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_en_q       <= 1'b0;
      r_inc        <= 1'b1;
      r_cursor     <= 7'h00;
      r_display_on <= 1'b0;
      r_rdata      <= 8'h00;
      r_char_valid <= 1'b0;
      r_char_data  <= 8'h00;
      r_char_addr  <= 7'h00;
      r_dropped    <= 1'b0;
    end else begin
      r_en_q       <= lcd_enable;
      r_char_valid <= 1'b0;
      r_dropped    <= w_strobe & ~w_idle;

      case (lcd_ctrl)
        CTRL_STAT_RD: r_rdata <= {~w_idle, r_cursor};
        CTRL_DATA_RD: r_rdata <= r_buf[w_cur_idx];
        default:      r_rdata <= 8'h00;
      endcase

      if (!w_idle) begin
        if (r_cnt == '0) r_state <= ST_IDLE;
        else             r_cnt   <= r_cnt - 1'b1;
      end

      if (w_sweep_on) r_buf[w_sweep_off[4:0]] <= 8'h20;

      if (w_accept) begin
        case (lcd_ctrl)
          CTRL_CMD_WR: begin
            r_state <= ST_BUSY;
            r_cnt   <= LP_CMD_LAST;
            if (lcd_data[7])      r_cursor     <= {lcd_data[6], 2'b00, lcd_data[3:0]};
            else if (lcd_data[3]) r_display_on <= lcd_data[2];
            else if (lcd_data[2]) r_inc        <= lcd_data[1];
            else if (lcd_data[1]) r_cursor     <= 7'h00;
            else if (lcd_data[0]) begin
              r_cursor <= 7'h00;
              r_inc    <= 1'b1;
              r_state  <= ST_CLEAR;
              r_cnt    <= LP_CLR_LAST;
            end
          end
          CTRL_DATA_WR: begin
            r_buf[w_cur_idx] <= lcd_data;
            r_char_valid     <= 1'b1;
            r_char_data      <= lcd_data;
            r_char_addr      <= r_cursor;
            r_cursor         <= w_cur_next;
            r_state          <= ST_BUSY;
            r_cnt            <= LP_CMD_LAST;
          end
          CTRL_DATA_RD: begin
            r_cursor <= w_cur_next;
            r_state  <= ST_BUSY;
            r_cnt    <= LP_CMD_LAST;
          end
          default: ;
        endcase
      end
    end
  end

  assign lcd_rdata  = r_rdata;
  assign busy       = ~w_idle;
  assign display_on = r_display_on;
  assign cursor     = r_cursor;
  assign char_valid = r_char_valid;
  assign char_data  = r_char_data;
  assign char_addr  = r_char_addr;
  assign dropped    = r_dropped;
  assign view_char  = r_buf[view_addr];

endmodule
